// File: rtl/sprite_pkg.sv
// sprite_pkg
//   Shared constants and types for the sprite address generator.
//   DIR_OFF     : sheet X offset per facing direction (0, 37, 91, 110)
//   OVL_SHIFT   : overlay coordinate down-scale (screen pixel -> sheet texel)
//   anim_state_t: per-channel explosion animation state
package sprite_pkg;

    localparam int OVL_SHIFT = 2;

    typedef enum logic {
        ANIM_IDLE = 1'b0,
        ANIM_BOOM = 1'b1
    } anim_state_t;

    function automatic logic [6:0] dir_off(input logic [1:0] dir);
        logic [6:0] off;
        case (dir)
            2'd0:    off = 7'd0;
            2'd1:    off = 7'd37;
            2'd2:    off = 7'd91;
            default: off = 7'd110;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/sprite_anim_ctr.sv
// sprite_anim_ctr
//   Explosion animation FSM for one sprite channel.
//   Ports:
//     clk_i, reset_i : clock, synchronous active-high reset
//     boom_start_i   : restart animation at frame 0 (wins over frame_tick_i)
//     frame_tick_i   : advance one animation frame
//     boom_o         : channel is exploding
//     frame_o        : current animation frame
//     done_o         : one-cycle pulse after the last frame has been ticked away
//
//   state     | meaning
//   ANIM_IDLE | channel drawn with its facing-direction offset
//   ANIM_BOOM | channel drawn with explosion frame frame_q
module sprite_anim_ctr
    import sprite_pkg::*;
#(
    parameter int ANIM_FRAMES = 4,
    localparam int FW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          boom_start_i,
    input  logic          frame_tick_i,
    output logic          boom_o,
    output logic [FW-1:0] frame_o,
    output logic          done_o
);

    anim_state_t   state_q, state_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          done_q, done_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ANIM_IDLE;
            frame_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        done_d  = 1'b0;
        if (boom_start_i) begin
            state_d = ANIM_BOOM;
            frame_d = '0;
        end else if (state_q == ANIM_BOOM && frame_tick_i) begin
            if (frame_q == FW'(ANIM_FRAMES - 1)) begin
                state_d = ANIM_IDLE;
                frame_d = '0;
                done_d  = 1'b1;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
    end

    assign boom_o  = (state_q == ANIM_BOOM);
    assign frame_o = frame_q;
    assign done_o  = done_q;

endmodule

// File: rtl/sprite_addr_gen.sv
// sprite_addr_gen
//   Two-stage sprite-ROM address generator. Stage 1 picks the winning source
//   (overlay, else highest-index hit channel) and registers its fields plus the
//   X offset snapshot; stage 2 forms (y)*SHEET_W + x + offset modulo 2^ADDR_W.
//   Build option: define SPRITE_ANIM_EN to build the per-channel explosion
//   animation (frame * ANIM_STRIDE offset, anim_done). Without it boom_start
//   and frame_tick are ignored and anim_done is tied low.
//   Ports:
//     Clk, Reset                : clock, synchronous active-high reset
//     DrawX, DrawY              : current pixel
//     frame_tick, boom_start    : animation controls
//     ch_hit/ch_dx/ch_dy        : per-channel coverage and in-box offset
//     ch_base_x/ch_base_y/ch_dir: per-channel sheet origin and facing
//     ovl_en, ovl_x, ovl_y      : full-screen overlay
//     Addr_out, addr_valid      : ROM address, 2 cycles after inputs
//     ch_sel                    : winning source (NUM_CH = overlay)
//     anim_done                 : per-channel end-of-explosion pulse
module sprite_addr_gen
    import sprite_pkg::*;
#(
    parameter int NUM_CH      = 8,
    parameter int SHEET_W     = 320,
    parameter int ADDR_W      = 20,
    parameter int ANIM_FRAMES = 4,
    parameter int ANIM_STRIDE = 19,
    localparam int SW = $clog2(NUM_CH) + 1,
    localparam int FW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [9:0]             DrawX,
    input  logic [9:0]             DrawY,
    input  logic                   frame_tick,
    input  logic [NUM_CH-1:0]      ch_hit,
    input  logic [NUM_CH-1:0][9:0] ch_dx,
    input  logic [NUM_CH-1:0][9:0] ch_dy,
    input  logic [NUM_CH-1:0][9:0] ch_base_x,
    input  logic [NUM_CH-1:0][9:0] ch_base_y,
    input  logic [NUM_CH-1:0][1:0] ch_dir,
    input  logic [NUM_CH-1:0]      boom_start,
    input  logic                   ovl_en,
    input  logic [9:0]             ovl_x,
    input  logic [9:0]             ovl_y,
    output logic [ADDR_W-1:0]      Addr_out,
    output logic                   addr_valid,
    output logic [SW-1:0]          ch_sel,
    output logic [NUM_CH-1:0]      anim_done
);

    logic [ADDR_W-1:0] xoff_ch [NUM_CH];

`ifdef SPRITE_ANIM_EN
    for (genvar g = 0; g < NUM_CH; g++) begin : g_anim
        logic          boom_w;
        logic [FW-1:0] frame_w;

        sprite_anim_ctr #(.ANIM_FRAMES(ANIM_FRAMES)) u_ctr (
            .clk_i        (Clk),
            .reset_i      (Reset),
            .boom_start_i (boom_start[g]),
            .frame_tick_i (frame_tick),
            .boom_o       (boom_w),
            .frame_o      (frame_w),
            .done_o       (anim_done[g])
        );

        assign xoff_ch[g] = boom_w ? ADDR_W'(frame_w) * ADDR_W'(ANIM_STRIDE)
                                   : ADDR_W'(dir_off(ch_dir[g]));
    end
`else
    for (genvar g = 0; g < NUM_CH; g++) begin : g_dir
        assign xoff_ch[g] = ADDR_W'(dir_off(ch_dir[g]));
    end
    assign anim_done = '0;
    logic unused_anim;
    assign unused_anim = ^{boom_start, frame_tick};
`endif

    // Stage 1: priority select. Later loop iterations overwrite earlier ones,
    // so the highest hit index wins; overlay is applied last and beats all.
    logic              win_valid;
    logic [SW-1:0]     win_sel;
    logic [9:0]        win_bx, win_by, win_dx, win_dy;
    logic [ADDR_W-1:0] win_xoff;

    always_comb begin
        win_valid = 1'b0;
        win_sel   = '0;
        win_bx    = '0;
        win_by    = '0;
        win_dx    = '0;
        win_dy    = '0;
        win_xoff  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_hit[i]) begin
                win_valid = 1'b1;
                win_sel   = SW'(i);
                win_bx    = ch_base_x[i];
                win_by    = ch_base_y[i];
                win_dx    = ch_dx[i];
                win_dy    = ch_dy[i];
                win_xoff  = xoff_ch[i];
            end
        end
        if (ovl_en) begin
            win_valid = 1'b1;
            win_sel   = SW'(NUM_CH);
            win_bx    = ovl_x;
            win_by    = ovl_y;
            win_dx    = DrawX >> OVL_SHIFT;
            win_dy    = DrawY >> OVL_SHIFT;
            win_xoff  = '0;
        end
    end

    logic              s1_valid_q;
    logic [SW-1:0]     s1_sel_q;
    logic [9:0]        s1_bx_q, s1_by_q, s1_dx_q, s1_dy_q;
    logic [ADDR_W-1:0] s1_xoff_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid_q <= 1'b0;
            s1_sel_q   <= '0;
            s1_bx_q    <= '0;
            s1_by_q    <= '0;
            s1_dx_q    <= '0;
            s1_dy_q    <= '0;
            s1_xoff_q  <= '0;
        end else begin
            s1_valid_q <= win_valid;
            s1_sel_q   <= win_sel;
            s1_bx_q    <= win_bx;
            s1_by_q    <= win_by;
            s1_dx_q    <= win_dx;
            s1_dy_q    <= win_dy;
            s1_xoff_q  <= win_xoff;
        end
    end

    // Stage 2: address arithmetic, all operands widened to ADDR_W first.
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic              valid_q;
    logic [SW-1:0]     sel_q;

    always_comb begin
        addr_d = '0;
        if (s1_valid_q) begin
            addr_d = (ADDR_W'(s1_by_q) + ADDR_W'(s1_dy_q)) * ADDR_W'(SHEET_W)
                   + ADDR_W'(s1_bx_q) + ADDR_W'(s1_dx_q) + s1_xoff_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            addr_q  <= '0;
            valid_q <= 1'b0;
            sel_q   <= '0;
        end else begin
            addr_q  <= addr_d;
            valid_q <= s1_valid_q;
            sel_q   <= s1_sel_q;
        end
    end

    assign Addr_out   = addr_q;
    assign addr_valid = valid_q;
    assign ch_sel     = sel_q;

endmodule

// File: tb/tb_sprite_addr_gen.sv
module tb_sprite_addr_gen;

    localparam int NUM_CH = 8;

    logic                   Clk = 1'b0;
    logic                   Reset;
    logic [9:0]             DrawX, DrawY;
    logic                   frame_tick;
    logic [NUM_CH-1:0]      ch_hit;
    logic [NUM_CH-1:0][9:0] ch_dx, ch_dy, ch_base_x, ch_base_y;
    logic [NUM_CH-1:0][1:0] ch_dir;
    logic [NUM_CH-1:0]      boom_start;
    logic                   ovl_en;
    logic [9:0]             ovl_x, ovl_y;
    logic [19:0]            Addr_out;
    logic                   addr_valid;
    logic [3:0]             ch_sel;
    logic [NUM_CH-1:0]      anim_done;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    sprite_addr_gen dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .frame_tick (frame_tick),
        .ch_hit     (ch_hit),
        .ch_dx      (ch_dx),
        .ch_dy      (ch_dy),
        .ch_base_x  (ch_base_x),
        .ch_base_y  (ch_base_y),
        .ch_dir     (ch_dir),
        .boom_start (boom_start),
        .ovl_en     (ovl_en),
        .ovl_x      (ovl_x),
        .ovl_y      (ovl_y),
        .Addr_out   (Addr_out),
        .addr_valid (addr_valid),
        .ch_sel     (ch_sel),
        .anim_done  (anim_done)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) if (anim_done[1]) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic set_ch(input int c, input int bx, input int by, input int dx,
                          input int dy, input int dir);
        ch_base_x[c] = 10'(bx);
        ch_base_y[c] = 10'(by);
        ch_dx[c]     = 10'(dx);
        ch_dy[c]     = 10'(dy);
        ch_dir[c]    = 2'(dir);
    endtask

    task automatic tick_once();
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; DrawX = '0; DrawY = '0; frame_tick = 1'b0;
        ch_hit = '0; ch_dx = '0; ch_dy = '0; ch_base_x = '0; ch_base_y = '0;
        ch_dir = '0; boom_start = '0; ovl_en = 1'b0; ovl_x = '0; ovl_y = '0;
        cyc(2);
        chk("rst_addr", 32'(Addr_out), 0);
        chk("rst_valid", 32'(addr_valid), 0);
        chk("rst_sel", 32'(ch_sel), 0);
        chk("rst_done", 32'(anim_done), 0);
        Reset = 1'b0;

        // ch2 wins over ch0 (both hit)
        set_ch(0, 1, 1, 1, 1, 0);
        set_ch(2, 0, 155, 3, 4, 1);
        ch_hit = 8'h05;
        cyc(2);
        chk("ch2_addr", 32'(Addr_out), 50920);
        chk("ch2_sel", 32'(ch_sel), 2);
        chk("ch2_valid", 32'(addr_valid), 1);

        // overlay alone
        ch_hit = '0; ovl_en = 1'b1; DrawX = 10'd40; DrawY = 10'd80;
        ovl_x = 10'd170; ovl_y = 10'd120;
        cyc(2);
        chk("ovl_addr", 32'(Addr_out), 44980);
        chk("ovl_sel", 32'(ch_sel), 8);
        chk("ovl_valid", 32'(addr_valid), 1);

        // overlay beats every channel
        ch_hit = 8'hFF;
        cyc(2);
        chk("ovl_prio_addr", 32'(Addr_out), 44980);
        chk("ovl_prio_sel", 32'(ch_sel), 8);

        // nothing hit
        ovl_en = 1'b0; ch_hit = '0;
        cyc(2);
        chk("none_valid", 32'(addr_valid), 0);
        chk("none_addr", 32'(Addr_out), 0);

        // highest index wins, dir=3: (2+1)*320 + 5+1 + 110 = 1076
        set_ch(7, 5, 2, 1, 1, 3);
        ch_hit = 8'h90;
        cyc(2);
        chk("ch7_addr", 32'(Addr_out), 1076);
        chk("ch7_sel", 32'(ch_sel), 7);

        // full-width operands: 2046*320 + 2046 + 110 = 656876
        set_ch(7, 1023, 1023, 1023, 1023, 3);
        cyc(2);
        chk("max_addr", 32'(Addr_out), 656876);

        // back-to-back pixels: ch2 then ch7
        ch_hit = 8'h04;
        cyc(1);
        ch_hit = 8'h80;
        cyc(1);
        chk("b2b_first", 32'(Addr_out), 50920);
        cyc(1);
        chk("b2b_second", 32'(Addr_out), 656876);

        // ch1 normal: 20*320 + 10 + 91 = 6501
        set_ch(1, 10, 20, 0, 0, 2);
        ch_hit = 8'h02;
        cyc(2);
        chk("ch1_normal", 32'(Addr_out), 6501);
        chk("ch1_sel", 32'(ch_sel), 1);

`ifdef SPRITE_ANIM_EN
        boom_start = 8'h02; cyc(1); boom_start = '0; cyc(2);
        chk("boom_f0", 32'(Addr_out), 6410);
        tick_once(); cyc(2);
        chk("boom_f1", 32'(Addr_out), 6429);
        tick_once(); cyc(2);
        chk("boom_f2", 32'(Addr_out), 6448);
        tick_once(); cyc(2);
        chk("boom_f3", 32'(Addr_out), 6467);
        frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
        chk("done_pulse", 32'(anim_done), 32'h02);
        cyc(1);
        chk("done_clear", 32'(anim_done), 0);
        cyc(1);
        chk("after_boom", 32'(Addr_out), 6501);
        chk("done_count", 32'(done_cnt), 1);

        // restart in BOOM(2) with a simultaneous tick
        boom_start = 8'h02; cyc(1); boom_start = '0;
        tick_once(); tick_once(); cyc(2);
        chk("boom2_again", 32'(Addr_out), 6448);
        boom_start = 8'h02; frame_tick = 1'b1; cyc(1);
        boom_start = '0; frame_tick = 1'b0; cyc(2);
        chk("restart_f0", 32'(Addr_out), 6410);

        // reset in BOOM(1) with pixels in flight
        tick_once(); cyc(2);
        chk("pre_rst_f1", 32'(Addr_out), 6429);
        Reset = 1'b1; frame_tick = 1'b1; boom_start = 8'h02; cyc(1);
        chk("rst_mid_addr", 32'(Addr_out), 0);
        chk("rst_mid_valid", 32'(addr_valid), 0);
        chk("rst_mid_sel", 32'(ch_sel), 0);
        chk("rst_mid_done", 32'(anim_done), 0);
        Reset = 1'b0; frame_tick = 1'b0; boom_start = '0; cyc(2);
        chk("post_rst_idle", 32'(Addr_out), 6501);
        tick_once(); cyc(2);
        chk("idle_tick", 32'(Addr_out), 6501);
        chk("rst_no_done", 32'(done_cnt), 1);
`else
        boom_start = 8'h02; cyc(1); boom_start = '0;
        tick_once(); cyc(2);
        chk("noanim_addr", 32'(Addr_out), 6501);
        chk("noanim_done", 32'(anim_done), 0);
        chk("noanim_count", 32'(done_cnt), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sprite_addr_gen.md
SPRITE_ADDR_GEN -- requirements
Module: sprite_addr_gen

Interface
REQ-001 Parameter NUM_CH, default 8: number of sprite channels.
REQ-002 Parameter SHEET_W, default 320: sprite-sheet row width in pixels.
REQ-003 Parameter ADDR_W, default 20: sprite-ROM address width.
REQ-004 Parameter ANIM_FRAMES, default 4: explosion animation frames per channel.
REQ-005 Parameter ANIM_STRIDE, default 19: sheet X offset between explosion frames.
REQ-006 Clk  in  1: single clock; all state changes on its rising edge.
REQ-007 Reset  in  1: synchronous, active-high.
REQ-008 DrawX, DrawY  in  10 each: current pixel coordinate.
REQ-009 frame_tick  in  1: one-cycle pulse at frame start.
REQ-010 ch_hit  in  NUM_CH: channel covers the current pixel.
REQ-011 ch_dx, ch_dy  in  NUM_CH x 10: pixel offset inside the sprite box.
REQ-012 ch_base_x, ch_base_y  in  NUM_CH x 10: sprite origin in the sheet.
REQ-013 ch_dir  in  NUM_CH x 2: facing direction.
REQ-014 boom_start  in  NUM_CH: one-cycle pulse that starts explosion animation.
REQ-015 ovl_en  in  1: full-screen overlay, e.g. win or game-over screen.
REQ-016 ovl_x, ovl_y  in  10 each: overlay origin in the sheet.
REQ-017 Addr_out  out  ADDR_W: sprite-ROM address.
REQ-018 addr_valid  out  1: Addr_out is meaningful for this pixel.
REQ-019 ch_sel  out  clog2(NUM_CH)+1: winning source; value NUM_CH means overlay.
REQ-020 anim_done  out  NUM_CH: one-cycle pulse when a channel's explosion finishes.

Function
REQ-021 Priority: ovl_en beats all channels; among set ch_hit bits, the highest index wins.
REQ-022 Pipeline stage 1 registers the winner, its fields and the priority-encode result.
REQ-023 Pipeline stage 2 computes and registers the address; fixed latency is 2 Clk cycles from DrawX/DrawY/ch_* to Addr_out/addr_valid/ch_sel.
REQ-024 Normal channel address: (base_y + dy) * SHEET_W + base_x + dx + DIR_OFF[dir].
REQ-025 Exploding channel address: same as REQ-024 with DIR_OFF replaced by frame * ANIM_STRIDE.
REQ-026 Overlay address: ((DrawY>>2) + ovl_y) * SHEET_W + (DrawX>>2) + ovl_x.
REQ-027 All arithmetic is zero-extended to ADDR_W; overflow truncates modulo 2^ADDR_W with no saturation.
REQ-028 No hit and no overlay: addr_valid=0 and Addr_out=0 for that pixel.
REQ-029 Per-channel animation FSM has states IDLE and BOOM(frame).
REQ-030 boom_start moves the channel to BOOM(0) from any state.
REQ-031 In BOOM, frame_tick advances frame; on frame_tick at ANIM_FRAMES-1 the channel returns to IDLE and pulses anim_done one cycle later.
REQ-032 boom_start and frame_tick in the same cycle: boom_start wins, giving BOOM(0).
REQ-033 The stage-1 snapshot of the animation state applies to the whole pixel; a state change mid-pipeline does not alter an address already in flight.

Reset
REQ-034 Reset clears both pipeline stages, so Addr_out=0, addr_valid=0, ch_sel=0 and anim_done=0 on the cycle after Reset is sampled high.
REQ-035 Reset returns all channels to IDLE, frame=0.
REQ-036 Reset mid-animation aborts the animation without an anim_done pulse.
REQ-037 Reset overrides boom_start and frame_tick.

Configuration
REQ-038 Macro SPRITE_ANIM_EN defined: the animation FSMs, REQ-025 and anim_done are built.
REQ-039 Macro SPRITE_ANIM_EN undefined: no FSM is built, every channel uses REQ-024, anim_done is tied 0 and boom_start is ignored.

Structure
REQ-040 Package sprite_pkg holds DIR_OFF = {0, 37, 91, 110}, the ovl shift constant (2) and the anim_state_t typedef.
REQ-041 One sub-module, sprite_anim_ctr, implements a single channel's FSM and is instantiated NUM_CH times.

Verification
REQ-042 ch_hit=8'h05, ch2: base (0,155), d=(3,4), dir=01 -> after 2 cycles Addr_out=159*320+3+37=50920, ch_sel=2, addr_valid=1.
REQ-043 ch_hit=0, ovl_en=1, DrawX=40, DrawY=80, ovl=(170,120) -> Addr_out=140*320+180=44980, ch_sel=8.
REQ-044 boom_start[1] then 4 frame_ticks -> frames 0,1,2,3 at X offsets 0,19,38,57; anim_done[1] pulses once; ch1 back to normal address.
REQ-045 boom_start[1] and frame_tick together while in BOOM(2) -> frame=0.
REQ-046 Reset asserted while in BOOM(1) with valid pixels in flight -> outputs 0 next cycle, no anim_done, channel in IDLE.
REQ-047 Build without SPRITE_ANIM_EN, pulse boom_start -> address unchanged, anim_done stays 0.
